// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared widths, ROM word layout and player state encoding
package music_pkg;

  localparam int TRACK_W = 6;
  localparam int DUR_W   = 6;
  localparam int WORD_W  = TRACK_W + DUR_W;

  localparam logic [TRACK_W-1:0] TRACK_REST = 6'd0;
  localparam int                 TRACK_MAX  = 36;

  // ROM word: [11:6] track code, [5:0] duration in ticks (0 = end of song)
  localparam int TRACK_MSB = 11;
  localparam int TRACK_LSB = 6;
  localparam int DUR_MSB   = 5;
  localparam int DUR_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LOAD = 3'd2,
    ST_PLAY = 3'd3,
    ST_DONE = 3'd4
  } player_state_t;

  // Codes above the highest lamp/tone are played as a rest
  function automatic logic [TRACK_W-1:0] legal_track(input logic [TRACK_W-1:0] code,
                                                     input logic [TRACK_W-1:0] max_code);
    return (code > max_code) ? TRACK_REST : code;
  endfunction

endpackage

// File: rtl/tempo_tick.sv
// rtl/tempo_tick.sv - enabled prescaler emitting one tick per TICK_DIV enabled cycles
module tempo_tick #(
  parameter int TICK_DIV = 6_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // The wrap cycle itself is the tick, so a frozen (disabled) counter never ticks
  assign tick = en && (cnt == LAST);

  // Count enabled cycles; clear wins so a fresh note always starts a full tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/music_track_player.sv
// rtl/music_track_player.sv - walks the song ROM and holds each note's track code for its duration
module music_track_player #(
  parameter int TICK_DIV  = 6_250_000,
  parameter int ADDR_W    = 8,
  parameter int TRACK_MAX = music_pkg::TRACK_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [5:0]        track,
  output logic              playing,
  output logic              song_done
);

  import music_pkg::*;

  localparam logic [TRACK_W-1:0] MAX_CODE = TRACK_MAX[TRACK_W-1:0];

  player_state_t      state;
  player_state_t      state_nx;
  logic [TRACK_W-1:0] note;
  logic [DUR_W-1:0]   remaining;
  logic [TRACK_W-1:0] rom_track;
  logic [DUR_W-1:0]   rom_dur;
  logic               tick;
  logic               tick_en;
  logic               tick_clr;
  logic               note_end;
  logic               last_addr;

  assign rom_track = rom_data[TRACK_MSB:TRACK_LSB];
  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
  assign tick_en   = (state == ST_PLAY) && !pause;
  assign tick_clr  = stop || start || (state == ST_LOAD);
  assign note_end  = tick && (remaining == DUR_W'(1));
  assign last_addr = &rom_addr;

  tempo_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tempo_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Next-state: stop beats start beats normal sequencing
  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = ST_IDLE;
    end else if (start) begin
      state_nx = ST_REQ;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_IDLE;
        ST_REQ:  state_nx = ST_LOAD;
        ST_LOAD: state_nx = (rom_dur == '0) ? ST_DONE : ST_PLAY;
        ST_PLAY: if (note_end) state_nx = last_addr ? ST_DONE : ST_REQ;
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State plus status flags registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_nx;
      playing   <= (state_nx == ST_PLAY);
      song_done <= (state_nx == ST_DONE);
    end
  end

  // Address, note and duration bookkeeping; track holds through REQ/LOAD to avoid a rest glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      track     <= TRACK_REST;
      note      <= TRACK_REST;
      remaining <= '0;
    end else if (stop) begin
      rom_addr <= '0;
      track    <= TRACK_REST;
    end else if (start) begin
      rom_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: track <= TRACK_REST;
        ST_LOAD: begin
          if (rom_dur != '0) begin
            note      <= legal_track(rom_track, MAX_CODE);
            track     <= legal_track(rom_track, MAX_CODE);
            remaining <= rom_dur;
          end
        end
        ST_PLAY: begin
          track <= pause ? TRACK_REST : note;
          if (tick) begin
            remaining <= remaining - 1'b1;
            if (remaining == DUR_W'(1) && !last_addr) begin
              rom_addr <= rom_addr + 1'b1;
            end
          end
        end
        ST_DONE: begin
          track    <= TRACK_REST;
          rom_addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_music_track_player.sv
// tb/tb_music_track_player.sv - directed tables plus randomized songs against a note-timeline model
module tb_music_track_player;

  localparam int TICK_DIV = 4;
  localparam int PV_N     = 4096;

  typedef struct packed {
    logic [5:0] trk;
    logic       ply;
    logic       dn;
    logic [7:0] addr;
  } obs_t;

  typedef struct {
    logic st;
    logic sp;
    logic pz;
    int   n;
    obs_t exp;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  track;
  logic        playing;
  logic        song_done;

  logic [11:0] rom [256];
  logic        pause_v [PV_N];
  obs_t        exp_q [$];
  seg_t        tbl [$];
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  music_track_player #(
    .TICK_DIV(TICK_DIV),
    .ADDR_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .track    (track),
    .playing  (playing),
    .song_done(song_done)
  );

  function automatic obs_t mk(input int t, input int p, input int d, input int a);
    obs_t o;
    o.trk  = t[5:0];
    o.ply  = p[0];
    o.dn   = d[0];
    o.addr = a[7:0];
    return o;
  endfunction

  function automatic logic [11:0] word(input int t, input int d);
    logic [11:0] w;
    w = {t[5:0], d[5:0]};
    return w;
  endfunction

  function automatic void row(input logic st, input logic sp, input logic pz, input int n,
                              input int t, input int p, input int d, input int a);
    seg_t s;
    s.st = st; s.sp = sp; s.pz = pz; s.n = n; s.exp = mk(t, p, d, a);
    tbl.push_back(s);
  endfunction

  // Expected observation after every edge, starting at the start edge, from the song rules:
  // two fetch edges, dur*TICK_DIV unpaused PLAY edges per note, rest while paused, done pulse.
  function automatic void build_trace();
    int addr, dur, tr, note, prev, need, e;
    logic pz;
    addr = 0; prev = 0;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0));
    while (1) begin
      exp_q.push_back(mk(prev, 0, 0, addr));
      dur = int'(rom[addr][5:0]);
      tr  = int'(rom[addr][11:6]);
      if (dur == 0) begin
        exp_q.push_back(mk(prev, 0, 1, addr));
        exp_q.push_back(mk(0, 0, 0, 0));
        return;
      end
      note = (tr > 36) ? 0 : tr;
      need = dur * TICK_DIV;
      exp_q.push_back(mk(note, 1, 0, addr));
      while (need > 0) begin
        e  = exp_q.size();
        pz = (e < PV_N) ? pause_v[e] : 1'b0;
        if (pz) begin
          exp_q.push_back(mk(0, 1, 0, addr));
        end else begin
          need--;
          if (need > 0) exp_q.push_back(mk(note, 1, 0, addr));
        end
      end
      if (addr == 255) begin
        exp_q.push_back(mk(note, 0, 1, 255));
        exp_q.push_back(mk(0, 0, 0, 0));
        return;
      end
      addr++;
      prev = note;
      exp_q.push_back(mk(note, 0, 0, addr));
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input obs_t exp);
    obs_t act;
    act.trk = track; act.ply = playing; act.dn = song_done; act.addr = rom_addr;
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got track=%0d playing=%0d done=%0d addr=%0d, want track=%0d playing=%0d done=%0d addr=%0d",
                  nm, act.trk, act.ply, act.dn, act.addr, exp.trk, exp.ply, exp.dn, exp.addr);
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[r]) begin
      start = tbl[r].st; stop = tbl[r].sp; pause = tbl[r].pz;
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        start = 1'b0; stop = 1'b0;
        chk($sformatf("%s.r%0d.%0d", nm, r, k), tbl[r].exp);
      end
    end
    pause = 1'b0;
    tbl.delete();
  endtask

  task automatic run_model(input string nm);
    build_trace();
    start = 1'b1;
    foreach (exp_q[e]) begin
      pause = (e < PV_N) ? pause_v[e] : 1'b0;
      step();
      start = 1'b0;
      chk($sformatf("%s.e%0d", nm, e), exp_q[e]);
    end
    pause = 1'b0;
  endtask

  task automatic clear_rom_pause();
    for (int i = 0; i < 256; i++) rom[i] = 12'd0;
    for (int i = 0; i < PV_N; i++) pause_v[i] = 1'b0;
  endtask

  initial begin
    clear_rom_pause();
    #2 rst_n = 1'b0;
    #1 chk("reset_async", mk(0, 0, 0, 0));
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset_idle", mk(0, 0, 0, 0));

    // Basic two-note song with end of song
    rom[0] = word(5, 2); rom[1] = word(12, 1); rom[2] = word(3, 0);
    row(1, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 8, 5, 1, 0, 0);
    row(0, 0, 0, 2, 5, 0, 0, 1);
    row(0, 0, 0, 4, 12, 1, 0, 1);
    row(0, 0, 0, 2, 12, 0, 0, 2);
    row(0, 0, 0, 1, 12, 0, 1, 2);
    row(0, 0, 0, 3, 0, 0, 0, 0);
    run_tbl("song1");

    // start+stop together, restart from idle, restart while playing, stop mid-fetch
    row(1, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 5, 5, 1, 0, 0);
    row(1, 1, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 3, 0, 0, 0, 0);
    row(1, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 3, 5, 1, 0, 0);
    row(1, 0, 0, 1, 5, 0, 0, 0);
    row(0, 0, 0, 1, 5, 0, 0, 0);
    row(0, 0, 0, 8, 5, 1, 0, 0);
    row(0, 0, 0, 2, 5, 0, 0, 1);
    row(0, 1, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 2, 0, 0, 0, 0);
    run_tbl("startstop");

    // Pause for 10 cycles mid-note keeps the remaining ticks
    rom[0] = word(9, 2); rom[1] = word(4, 1); rom[2] = word(0, 0);
    row(1, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 4, 9, 1, 0, 0);
    row(0, 0, 1, 10, 0, 1, 0, 0);
    row(0, 0, 0, 4, 9, 1, 0, 0);
    row(0, 0, 0, 2, 9, 0, 0, 1);
    row(0, 0, 0, 4, 4, 1, 0, 1);
    row(0, 0, 0, 2, 4, 0, 0, 2);
    row(0, 0, 0, 1, 4, 0, 1, 2);
    row(0, 0, 0, 2, 0, 0, 0, 0);
    run_tbl("pause");

    // Repeated note must not glitch to 0 between entries
    clear_rom_pause();
    rom[0] = word(7, 1); rom[1] = word(7, 1);
    run_model("repeat7");

    // Illegal code plays as rest; boundary codes 36/37
    clear_rom_pause();
    rom[0] = word(40, 3); rom[1] = word(6, 1); rom[2] = word(36, 1); rom[3] = word(37, 1);
    run_model("illegal");

    // Randomized songs with bursty pause, including pause during fetch
    for (int s = 0; s < 8; s++) begin
      int len;
      logic p;
      clear_rom_pause();
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) rom[i] = word($urandom_range(0, 63), $urandom_range(1, 3));
      rom[len] = word($urandom_range(0, 63), 0);
      p = 1'b0;
      for (int e = 0; e < 400; e++) begin
        if ($urandom_range(0, 7) == 0) p = !p;
        pause_v[e] = p;
      end
      run_model($sformatf("rand%0d", s));
    end

    // Asynchronous reset in the middle of the second note
    clear_rom_pause();
    rom[0] = word(5, 2); rom[1] = word(12, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("pre_reset", mk(12, 1, 0, 1));
    #3 rst_n = 1'b0;
    #1 chk("mid_note_reset", mk(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset", mk(0, 0, 0, 0));

    // Full ROM without terminator: done after entry 255, address back to 0
    clear_rom_pause();
    for (int i = 0; i < 256; i++) rom[i] = word((i * 7) % 64, 1);
    run_model("fullrom");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
